// File: rtl/irq_dispatch.sv
// Interrupt front-end: syncs 16 request lines, holds pending state, and
// dispatches the encoder's winning index to the core, holding off until EOI.
//
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   irq_in, irq_mask        raw request lines and per-source enables
//   enc_vector              masked pending vector to the priority encoder
//   enc_addr, enc_match     encoder result (highest set bit, any bit set)
//   req_valid, req_id       dispatch offer to the core
//   req_ready               core accepts the offer
//   eoi                     end-of-interrupt pulse from the core
//   in_service              an accepted request is awaiting EOI
//   pending                 raw unmasked pending register
module irq_dispatch #(
  parameter logic [15:0] EDGE_SRC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] irq_in,
  input  logic [15:0] irq_mask,
  output logic [15:0] enc_vector,
  input  logic [3:0]  enc_addr,
  input  logic        enc_match,
  output logic        req_valid,
  output logic [3:0]  req_id,
  input  logic        req_ready,
  input  logic        eoi,
  output logic        in_service,
  output logic [15:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] s1_q, s1_d;
  logic [15:0] s2_q, s2_d;
  logic [15:0] s3_q, s3_d;
  logic [15:0] pend_q, pend_d;
  logic        req_valid_q, req_valid_d;
  logic [3:0]  req_id_q, req_id_d;
  logic        in_service_q, in_service_d;

  logic [15:0] rise;
  logic [15:0] clr;
  logic        accept;

  // Synchroniser chain and pending update.
  always_comb begin
    s1_d   = irq_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise   = s2_q & ~s3_q;
    accept = (state_q == OFFER) && req_ready;
    clr    = accept ? (16'h0001 << req_id_q) : 16'h0000;
    // Edge bits: set wins over a same-cycle clear so no event is lost.
    // Level bits simply follow the synchronised line.
    pend_d = (EDGE_SRC & ((pend_q & ~clr) | rise))
           | (~EDGE_SRC & s2_q);
  end

  // Dispatch FSM.
  always_comb begin
    state_d      = state_q;
    req_valid_d  = req_valid_q;
    req_id_d     = req_id_q;
    in_service_d = in_service_q;
    unique case (state_q)
      IDLE: begin
        if (enc_match) begin
          req_id_d    = enc_addr;
          req_valid_d = 1'b1;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        // Offer is never withdrawn; req_id stays frozen until accepted.
        if (req_ready) begin
          req_valid_d  = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        req_valid_d  = 1'b0;
        in_service_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      pend_q       <= '0;
      req_valid_q  <= 1'b0;
      req_id_q     <= '0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      pend_q       <= pend_d;
      req_valid_q  <= req_valid_d;
      req_id_q     <= req_id_d;
      in_service_q <= in_service_d;
    end
  end

  assign enc_vector = pend_q & irq_mask;
  assign pending    = pend_q;
  assign req_valid  = req_valid_q;
  assign req_id     = req_id_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_dispatch.sv
// Bench for irq_dispatch: behavioural model compared every cycle plus
// directed scenarios with literal expectations.
module tb_irq_dispatch;

  localparam logic [15:0] EDGES = 16'h0021;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] irq_in;
  logic [15:0] irq_mask;
  logic [15:0] enc_vector;
  logic [3:0]  enc_addr;
  logic        enc_match;
  logic        req_valid;
  logic [3:0]  req_id;
  logic        req_ready;
  logic        eoi;
  logic        in_service;
  logic [15:0] pending;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  irq_dispatch #(.EDGE_SRC(EDGES)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .enc_vector (enc_vector),
    .enc_addr   (enc_addr),
    .enc_match  (enc_match),
    .req_valid  (req_valid),
    .req_id     (req_id),
    .req_ready  (req_ready),
    .eoi        (eoi),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clock = ~clock;

  function automatic int top_bit(input logic [15:0] v);
    int r = 0;
    for (int i = 0; i < 16; i++)
      if (v[i]) r = i;
    return r;
  endfunction

  // External priority encoder stand-in.
  assign enc_match = |enc_vector;
  assign enc_addr  = 4'(top_bit(enc_vector));

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = free, 1 = offered, 2 = being serviced.
  logic [15:0] m_h1, m_h2, m_h3, m_pend;
  int          m_phase, m_id;

  always @(posedge clock) begin
    logic [15:0] np;
    if (!reset_n) begin
      m_h1 = '0; m_h2 = '0; m_h3 = '0; m_pend = '0;
      m_phase = 0; m_id = 0;
      started = 1'b1;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (EDGES[i]) begin
          np[i] = m_pend[i];
          if (m_phase == 1 && req_ready && m_id == i) np[i] = 1'b0;
          if (m_h2[i] && !m_h3[i]) np[i] = 1'b1;
        end else begin
          np[i] = m_h2[i];
        end
      end
      if (m_phase == 0) begin
        if ((m_pend & irq_mask) != 0) begin
          m_id    = top_bit(m_pend & irq_mask);
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (req_ready) m_phase = 2;
      end else begin
        if (eoi) m_phase = 0;
      end
      m_pend = np;
      m_h3 = m_h2; m_h2 = m_h1; m_h1 = irq_in;
    end
  end

  always @(negedge clock) begin
    if (started) begin
      chk("m_req_valid", 16'(req_valid), 16'(m_phase == 1));
      chk("m_in_service", 16'(in_service), 16'(m_phase == 2));
      chk("m_req_id", 16'(req_id), 16'(m_id));
      chk("m_pending", pending, m_pend);
      chk("m_enc_vector", enc_vector, m_pend & irq_mask);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_valid(input string nm);
    int k = 0;
    while (!req_valid && k < 20) begin
      tick(1);
      k++;
    end
    chk(nm, 16'(req_valid), 16'h1);
  endtask

  task automatic do_eoi;
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  task automatic do_accept;
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    irq_in    = 16'hFFFF;
    irq_mask  = 16'h0000;
    req_ready = 1'b0;
    eoi       = 1'b0;
    tick(3);
    chk("rst_valid", 16'(req_valid), 16'h0);
    chk("rst_pending", pending, 16'h0000);
    chk("rst_in_service", 16'(in_service), 16'h0);
    reset_n = 1'b1;
    irq_in  = 16'h0000;
    tick(4);

    // Latency of an edge source.
    irq_mask  = 16'h0001;
    irq_in[0] = 1'b1;
    tick(1);
    irq_in[0] = 1'b0;
    tick(1);
    chk("lat_pend_n1", pending, 16'h0000);
    tick(1);
    chk("lat_pend_n2", pending, 16'h0001);
    chk("lat_valid_n2", 16'(req_valid), 16'h0);
    tick(1);
    chk("lat_valid_n3", 16'(req_valid), 16'h1);
    chk("lat_id_n3", 16'(req_id), 16'h0);
    do_accept();
    chk("lat_pend_clr", pending, 16'h0000);
    chk("lat_in_svc", 16'(in_service), 16'h1);
    do_eoi();
    chk("lat_eoi", 16'(in_service), 16'h0);

    // Priority and no preemption.
    irq_mask = 16'hFFFF;
    irq_in   = 16'h0208;
    wait_valid("pri_wait");
    chk("pri_id", 16'(req_id), 16'h9);
    do_accept();
    irq_in = 16'h8208;
    tick(6);
    chk("nopre_valid", 16'(req_valid), 16'h0);
    chk("nopre_pend", pending, 16'h8208);
    do_eoi();
    tick(1);
    chk("redisp_valid", 16'(req_valid), 16'h1);
    chk("redisp_id", 16'(req_id), 16'hF);

    // Stall with ready low while the source vanishes and gets masked.
    irq_in = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) irq_mask = 16'h0000;
      tick(1);
      chk("stall_valid", 16'(req_valid), 16'h1);
      chk("stall_id", 16'(req_id), 16'hF);
    end
    do_accept();
    do_eoi();
    tick(3);
    chk("stall_idle", 16'(req_valid), 16'h0);

    // Same-cycle set and clear on edge source 5.
    irq_mask  = 16'h0020;
    irq_in[5] = 1'b1;
    tick(1);
    irq_in[5] = 1'b0;
    wait_valid("sc_wait");
    chk("sc_id", 16'(req_id), 16'h5);
    irq_in[5] = 1'b1;
    tick(1);
    irq_in[5] = 1'b0;
    tick(1);
    do_accept();
    chk("sc_pend_kept", pending, 16'h0020);
    chk("sc_in_svc", 16'(in_service), 16'h1);
    do_eoi();
    tick(1);
    chk("sc_redisp", 16'(req_valid), 16'h1);
    chk("sc_redisp_id", 16'(req_id), 16'h5);
    do_accept();
    do_eoi();
    chk("sc_pend_done", pending, 16'h0000);

    // Reset in the middle of an offer.
    irq_mask = 16'h0200;
    irq_in   = 16'h0200;
    wait_valid("ro_wait");
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    irq_in  = 16'h0000;
    chk("ro_valid", 16'(req_valid), 16'h0);
    chk("ro_id", 16'(req_id), 16'h0);
    chk("ro_pend", pending, 16'h0000);
    chk("ro_in_svc", 16'(in_service), 16'h0);
    tick(5);
    chk("ro_quiet", 16'(req_valid), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
